// File: rtl/rb_burst_reader_if.sv
// rb_if: valid/ready stream carrying one data_t payload per beat.
// master drives valid/data, slave drives ready.
interface rb_if #(
  parameter type data_t = logic
);
  logic  valid;
  logic  ready;
  data_t data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/rb_burst_reader.sv
// rb_burst_reader: pulls a commanded number of beats from an rb_if source
// and forwards them through a two-entry skid stage, tagging the last beat.
module rb_burst_reader #(
  parameter type data_t = logic,
  parameter int  LW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          o_last,
  rb_if.slave           i_bus,
  rb_if.master          o_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [LW-1:0] rem;
  logic          out_v;
  logic          out_l;
  data_t         out_d;
  logic          spr_v;
  logic          spr_l;
  data_t         spr_d;

  logic in_rdy;
  logic acc;
  logic drain;
  logic to_out;
  logic acc_last;

  // ready depends only on registered state, never on o_bus.ready
  assign in_rdy   = (state == S_XFER) && (rem != '0) && !spr_v;
  assign acc      = i_bus.valid && in_rdy;
  assign drain    = out_v && o_bus.ready;
  assign to_out   = !out_v || drain;
  assign acc_last = (rem == LW'(1));

  assign i_bus.ready = in_rdy;
  assign o_bus.valid = out_v;
  assign o_bus.data  = out_d;
  assign o_last      = out_v && out_l;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rem   <= '0;
      out_v <= 1'b0;
      spr_v <= 1'b0;
    end else begin
      if (drain) begin
        out_v <= spr_v;
        spr_v <= 1'b0;
      end
      if (acc) begin
        rem <= rem - LW'(1);
        if (to_out) out_v <= 1'b1;
        else        spr_v <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            rem   <= len;
            state <= (len != '0) ? S_XFER : S_DONE;
          end
        end
        S_XFER: begin
          if (drain && out_l) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          out_v <= 1'b0;
          spr_v <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // payload registers carry no reset; validity lives in out_v/spr_v
  always_ff @(posedge clk) begin
    if (drain && spr_v) begin
      out_d <= spr_d;
      out_l <= spr_l;
    end
    if (acc) begin
      if (to_out) begin
        out_d <= i_bus.data;
        out_l <= acc_last;
      end else begin
        spr_d <= i_bus.data;
        spr_l <= acc_last;
      end
    end
  end

endmodule

// File: tb/tb_rb_burst_reader.sv
// Directed bench for rb_burst_reader: a queue models the upstream ring
// buffer and a scoreboard queue holds the beats expected downstream.
module tb_rb_burst_reader;

  typedef logic [7:0] byte_t;
  typedef struct {
    byte_t d;
    logic  l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic       o_last;

  rb_if #(.data_t(byte_t)) i_bus ();
  rb_if #(.data_t(byte_t)) o_bus ();

  rb_burst_reader #(
    .data_t(byte_t),
    .LW    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .o_last(o_last),
    .i_bus (i_bus),
    .o_bus (o_bus)
  );

  always #5 clk = ~clk;

  byte_t src[$];
  exp_t  sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int up_cnt, dn_cnt, done_cnt;
  int up_tot, dn_tot;
  int cur_len;
  int last_cyc, done_cyc, first_dn, last_dn;
  bit dn_mode;
  int pat;
  bit up_fire;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    i_bus.valid = (src.size() != 0);
    i_bus.data  = (src.size() != 0) ? src[0] : 8'h00;
  endtask

  task automatic clr();
    up_cnt = 0; dn_cnt = 0; done_cnt = 0;
    last_cyc = -1; done_cyc = -1; first_dn = -1; last_dn = -1;
  endtask

  task automatic push_exp(byte_t base, int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.d = base + byte_t'(i);
      e.l = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  // one clock: sample handshakes at negedge, apply effects after posedge
  task automatic tick();
    int occ;
    @(negedge clk);
    cyc++;
    occ = up_tot - dn_tot;
    if (occ > 2) chk("occupancy", occ, 2);
    if (occ == 2) chk("rdy_full", i_bus.ready, 0);
    if (busy && up_cnt >= cur_len) chk("rdy_after_len", i_bus.ready, 0);
    if (o_bus.valid && o_bus.ready) begin
      if (sb.size() == 0) begin
        chk("extra_beat", o_bus.data, 8'hxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", o_bus.data, e.d);
        chk("last", o_last, e.l);
      end
      if (o_last) last_cyc = cyc;
      if (first_dn < 0) first_dn = cyc;
      last_dn = cyc;
      dn_cnt++; dn_tot++;
    end
    up_fire = i_bus.valid && i_bus.ready;
    if (up_fire) begin up_cnt++; up_tot++; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    @(posedge clk);
    #1;
    if (up_fire) void'(src.pop_front());
    drive();
    o_bus.ready = dn_mode ? (pat == 0) : 1'b1;
    pat = (pat + 1) % 3;
  endtask

  task automatic cmd(int l);
    cur_len = l;
    drive();
    start = 1'b1;
    len = 8'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(string tag, int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, (done_cnt > d0), 1);
    chk({tag, "_done_lat"}, done_cyc, last_cyc + 1);
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    i_bus.valid = 1'b0;
    i_bus.data = '0;
    o_bus.ready = 1'b1;
    dn_mode = 0; pat = 0;
    up_tot = 0; dn_tot = 0; cur_len = 0;
    clr();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovalid", o_bus.valid, 0);
    chk("rst_olast", o_last, 0);
    chk("rst_iready", i_bus.ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic burst
    clr();
    for (int i = 0; i < 4; i++) src.push_back(8'h10 + byte_t'(i));
    push_exp(8'h10, 4);
    cmd(4);
    chk("basic_busy", busy, 1);
    chk("basic_first_rdy", i_bus.ready, 1);
    run_until_done("basic", 20);
    chk("basic_dn", dn_cnt, 4);
    chk("basic_up", up_cnt, 4);
    chk("basic_consec", last_dn - first_dn, 3);
    chk("basic_src", src.size(), 0);

    // partial drain
    clr();
    for (int i = 0; i < 6; i++) src.push_back(8'h20 + byte_t'(i));
    push_exp(8'h20, 3);
    cmd(3);
    run_until_done("partial", 20);
    chk("partial_dn", dn_cnt, 3);
    chk("partial_src", src.size(), 3);
    src.delete();
    drive();

    // backpressure
    clr();
    for (int i = 0; i < 8; i++) src.push_back(8'h30 + byte_t'(i));
    push_exp(8'h30, 8);
    dn_mode = 1; pat = 0;
    cmd(8);
    run_until_done("bp", 100);
    chk("bp_dn", dn_cnt, 8);
    chk("bp_sb", sb.size(), 0);
    dn_mode = 0;
    tick();

    // zero length
    clr();
    cmd(0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 1);
    chk("zero_ovalid", o_bus.valid, 0);
    tick();
    chk("zero_idle", busy, 0);
    chk("zero_done_off", done, 0);
    chk("zero_dn", dn_cnt, 0);

    // ignored start
    clr();
    for (int i = 0; i < 8; i++) src.push_back(8'h50 + byte_t'(i));
    push_exp(8'h50, 5);
    cmd(5);
    tick();
    start = 1'b1; len = 8'd3;
    tick();
    start = 1'b0;
    run_until_done("ign", 30);
    for (int i = 0; i < 4; i++) tick();
    chk("ign_dn", dn_cnt, 5);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_src", src.size(), 3);
    src.delete();
    drive();

    // starved upstream
    clr();
    src.push_back(8'h40);
    src.push_back(8'h41);
    push_exp(8'h40, 4);
    cmd(4);
    for (int i = 0; i < 10; i++) tick();
    chk("starve_dn", dn_cnt, 2);
    chk("starve_busy", busy, 1);
    chk("starve_ovalid", o_bus.valid, 0);
    src.push_back(8'h42);
    src.push_back(8'h43);
    drive();
    run_until_done("starve", 20);
    chk("starve_dn_end", dn_cnt, 4);

    // reset mid-burst
    clr();
    for (int i = 0; i < 6; i++) src.push_back(8'h60 + byte_t'(i));
    push_exp(8'h60, 6);
    cmd(6);
    for (int i = 0; i < 20 && dn_cnt < 2; i++) tick();
    chk("rst_mid_reach", dn_cnt, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", busy, 0);
    chk("rmid_done", done, 0);
    chk("rmid_ovalid", o_bus.valid, 0);
    chk("rmid_olast", o_last, 0);
    chk("rmid_iready", i_bus.ready, 0);
    sb.delete();
    src.delete();
    drive();
    up_tot = 0; dn_tot = 0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    clr();
    src.push_back(8'h70);
    push_exp(8'h70, 1);
    cmd(1);
    run_until_done("post_rst", 20);
    chk("post_rst_dn", dn_cnt, 1);
    chk("post_rst_sb", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
